// File: rtl/sseg_pkg.sv
// Shared definitions for the multiplexed 7-segment driver: segment bit order
// and the hex-to-segment decode table.
package sseg_pkg;

   localparam int SEG_W      = 8;
   localparam int SEG_A_BIT  = 0;
   localparam int SEG_G_BIT  = 6;
   localparam int SEG_DP_BIT = 7;

   // Active-high {g,f,e,d,c,b,a}; b and d are lower case so they differ from 8 and 0.
   function automatic logic [6:0] seg_decode(input logic [3:0] code);
      logic [6:0] segs;
      case (code)
         4'h0: segs = 7'h3F;
         4'h1: segs = 7'h06;
         4'h2: segs = 7'h5B;
         4'h3: segs = 7'h4F;
         4'h4: segs = 7'h66;
         4'h5: segs = 7'h6D;
         4'h6: segs = 7'h7D;
         4'h7: segs = 7'h07;
         4'h8: segs = 7'h7F;
         4'h9: segs = 7'h6F;
         4'hA: segs = 7'h77;
         4'hB: segs = 7'h7C;
         4'hC: segs = 7'h39;
         4'hD: segs = 7'h5E;
         4'hE: segs = 7'h79;
         default: segs = 7'h71;
      endcase
      return segs;
   endfunction

endpackage

// File: rtl/sseg_tick_gen.sv
// Scan prescaler: one tick per DIV clocks, plus a guard flag covering the
// first GUARD_CYCLES clocks of every digit slot.
module sseg_tick_gen #(
   parameter int DIV          = 10,
   parameter int GUARD_CYCLES = 2
)(
   input  logic clk,
   input  logic rst,
   output logic o_tick,
   output logic o_guard
);
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CNT_W-1:0] r_pre_cnt;

   always_ff @(posedge clk) begin
      if (rst)
         r_pre_cnt <= '0;
      else if (o_tick)
         r_pre_cnt <= '0;
      else
         r_pre_cnt <= r_pre_cnt + 1'b1;
   end

   assign o_tick  = (r_pre_cnt == CNT_W'(DIV - 1));
   assign o_guard = (int'(r_pre_cnt) < GUARD_CYCLES);

endmodule

// File: rtl/sseg_scan.sv
// Time-multiplexed N-digit 7-segment driver with double-buffered frame,
// hex decode, per-digit blank/DP, PWM brightness and anti-ghost guard.
module sseg_scan
   import sseg_pkg::*;
#(
   parameter int NUM_DIGITS     = 6,
   parameter int CLK_HZ         = 50_000_000,
   parameter int SCAN_HZ        = 1000,
   parameter int GUARD_CYCLES   = 2,
   parameter int BRIGHT_W       = 4,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int POS_ACTIVE_LOW = 1
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic                    load,
   input  logic [BRIGHT_W-1:0]     brightness,
   output logic [SEG_W-1:0]        digit_segs,
   output logic [NUM_DIGITS-1:0]   position,
   output logic                    frame_done
);
   localparam int DIV   = CLK_HZ / SCAN_HZ;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [BRIGHT_W-1:0]   PWM_LAST = BRIGHT_W'((2 ** BRIGHT_W) - 2);
   localparam logic [SEG_W-1:0]      SEG_INV  = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic [NUM_DIGITS-1:0] POS_INV  = (POS_ACTIVE_LOW != 0) ? '1 : '0;

   logic                    w_tick;
   logic                    w_guard;
   logic                    w_wrap;
   logic                    w_lit;
   logic                    w_on;
   logic [3:0]              w_code;
   logic                    w_dp;
   logic [NUM_DIGITS-1:0]   w_pos_onehot;
   logic [3:0]              w_code_arr [NUM_DIGITS];

   logic [IDX_W-1:0]        r_idx;
   logic [BRIGHT_W-1:0]     r_pwm_cnt;
   logic [4*NUM_DIGITS-1:0] r_stage_code;
   logic [NUM_DIGITS-1:0]   r_stage_dp;
   logic [NUM_DIGITS-1:0]   r_stage_blank;
   logic                    r_pending;
   logic [4*NUM_DIGITS-1:0] r_shadow_code;
   logic [NUM_DIGITS-1:0]   r_shadow_dp;
   logic [NUM_DIGITS-1:0]   r_shadow_blank;
   logic                    r_frame_done;
   logic [SEG_W-1:0]        r_digit_segs;
   logic [NUM_DIGITS-1:0]   r_position;

   sseg_tick_gen #(
      .DIV          (DIV),
      .GUARD_CYCLES (GUARD_CYCLES)
   ) u_tick_gen (
      .clk     (clk),
      .rst     (rst),
      .o_tick  (w_tick),
      .o_guard (w_guard)
   );

   assign w_wrap = w_tick && (r_idx == IDX_W'(NUM_DIGITS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx     <= '0;
         r_pwm_cnt <= '0;
      end else begin
         if (w_tick)
            r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
         r_pwm_cnt <= (r_pwm_cnt == PWM_LAST) ? '0 : r_pwm_cnt + 1'b1;
      end
   end

   // Shadow only changes on the frame_done cycle, so a frame is never torn.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stage_code   <= '0;
         r_stage_dp     <= '0;
         r_stage_blank  <= '1;
         r_pending      <= 1'b0;
         r_shadow_code  <= '0;
         r_shadow_dp    <= '0;
         r_shadow_blank <= '1;
      end else if (r_frame_done) begin
         if (load) begin
            r_shadow_code  <= digits_in;
            r_shadow_dp    <= dp_in;
            r_shadow_blank <= blank_in;
         end else if (r_pending) begin
            r_shadow_code  <= r_stage_code;
            r_shadow_dp    <= r_stage_dp;
            r_shadow_blank <= r_stage_blank;
         end
         r_pending <= 1'b0;
      end else if (load) begin
         r_stage_code  <= digits_in;
         r_stage_dp    <= dp_in;
         r_stage_blank <= blank_in;
         r_pending     <= 1'b1;
      end
   end

   // Digit 0 is the leftmost, so it drives the MSB of the position bus.
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_code_arr[gi]   = r_shadow_code[4*gi +: 4];
      assign w_pos_onehot[gi] = (r_idx == IDX_W'(NUM_DIGITS - 1 - gi));
   end

   assign w_code = w_code_arr[r_idx];
   assign w_dp   = r_shadow_dp[r_idx];
   assign w_lit  = (brightness > r_pwm_cnt);
   assign w_on   = w_lit && !w_guard && !r_shadow_blank[r_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_done <= 1'b0;
         r_digit_segs <= SEG_INV;
         r_position   <= POS_INV;
      end else begin
         r_frame_done <= w_wrap;
         r_digit_segs <= (w_on ? {w_dp, seg_decode(w_code)} : '0) ^ SEG_INV;
         r_position   <= (w_on ? w_pos_onehot : '0) ^ POS_INV;
      end
   end

   assign digit_segs = r_digit_segs;
   assign position   = r_position;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sseg_scan.sv
// Directed bench for sseg_scan at DIV=10, 6 digits, active-low outputs.
module tb_sseg_scan;
   localparam int ND = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load = 1'b0;
   logic [4*ND-1:0] digits_in = '0;
   logic [ND-1:0] dp_in = '0;
   logic [ND-1:0] blank_in = '0;
   logic [3:0]    brightness = 4'd15;
   logic [7:0]    digit_segs;
   logic [ND-1:0] position;
   logic          frame_done;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [5:0] exp_pos [ND] = '{6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E};
   logic [7:0] exp_seg [ND] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82};

   always #5 clk = ~clk;

   sseg_scan #(
      .NUM_DIGITS     (ND),
      .CLK_HZ         (1000),
      .SCAN_HZ        (100),
      .GUARD_CYCLES   (2),
      .BRIGHT_W       (4),
      .SEG_ACTIVE_LOW (1),
      .POS_ACTIVE_LOW (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .blank_in   (blank_in),
      .load       (load),
      .brightness (brightness),
      .digit_segs (digit_segs),
      .position   (position),
      .frame_done (frame_done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("[c=%0d] ok   %s = %0h", cyc, tag, got);
      end else begin
         $display("[c=%0d] FAIL %s: got %0h expected %0h", cyc, tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int t);
      while (cyc < t) step();
   endtask

   task automatic do_load(input logic [4*ND-1:0] d, input logic [ND-1:0] dp, input logic [ND-1:0] bl);
      digits_in = d;
      dp_in     = dp;
      blank_in  = bl;
      load      = 1'b1;
      step();
      load      = 1'b0;
      digits_in = 24'hFFFFFF;  // input changes without load must not show
   endtask

   initial begin
      int act;
      int fd_cnt;
      int fd_first;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
      chk("rst_pos", position, 6'h3F);
      chk("rst_segs", digit_segs, 8'hFF);
      chk("rst_fd", frame_done, 1'b0);

      act = 0; fd_cnt = 0; fd_first = -1;
      while (cyc < 130) begin
         step();
         if (position !== 6'h3F || digit_segs !== 8'hFF) act++;
         if (frame_done) begin
            fd_cnt++;
            if (fd_first < 0) fd_first = cyc;
         end
      end
      chk("idle_active_cycles", act, 0);
      chk("idle_fd_count", fd_cnt, 2);
      chk("idle_fd_first", fd_first, 60);

      // Load 1..6 mid-frame; shown from the frame starting at c=180.
      do_load(24'h654321, 6'b000000, 6'b000000);
      run_to(175);
      chk("old_frame_dark", position, 6'h3F);
      run_to(180);
      chk("fd_180", frame_done, 1'b1);
      run_to(182);
      chk("guard_d0", position, 6'h3F);
      run_to(183);
      chk("d0_first_pos", position, 6'h1F);
      chk("d0_first_segs", digit_segs, 8'hF9);
      run_to(190);
      chk("d0_last_pos", position, 6'h1F);
      run_to(191);
      chk("d1_guard_pos", position, 6'h3F);
      for (int d = 1; d < ND; d++) begin
         run_to(185 + 10*d);
         chk($sformatf("d%0d_pos", d), position, exp_pos[d]);
         chk($sformatf("d%0d_segs", d), digit_segs, exp_seg[d]);
      end

      // Two loads in frame 240..299: only the second appears from c=300.
      run_to(245);
      do_load(24'h000000, 6'b000000, 6'b000000);
      run_to(250);
      do_load(24'h00A000, 6'b001000, 6'b110111);
      run_to(275);
      chk("old_d3_pos", position, 6'h3B);
      chk("old_d3_segs", digit_segs, 8'h99);
      run_to(285);
      chk("old_d4_pos", position, 6'h3D);
      chk("old_d4_segs", digit_segs, 8'h92);
      run_to(300);
      chk("fd_300", frame_done, 1'b1);
      run_to(305);
      chk("new_d0_blank", position, 6'h3F);
      run_to(335);
      chk("A_dp_pos", position, 6'h3B);
      chk("A_dp_segs", digit_segs, 8'h08);
      run_to(345);
      chk("new_d4_blank", position, 6'h3F);

      // Load on the frame_done cycle goes straight to the shadow.
      run_to(360);
      chk("fd_360", frame_done, 1'b1);
      do_load(24'h777777, 6'b000000, 6'b000000);
      run_to(365);
      chk("coinc_pos", position, 6'h1F);
      chk("coinc_segs", digit_segs, 8'hF8);
      run_to(425);
      chk("no_stale_pos", position, 6'h1F);
      chk("no_stale_segs", digit_segs, 8'hF8);

      // Brightness 0: never active. Brightness 5: 8 of every 30 cycles.
      run_to(430);
      brightness = 4'd0;
      run_to(431);
      act = 0;
      while (cyc < 479) begin
         step();
         if (position !== 6'h3F) act++;
      end
      chk("bright0_active", act, 0);
      run_to(480);
      brightness = 4'd5;
      act = 0;
      while (cyc < 630) begin
         step();
         if (position !== 6'h3F) act++;
      end
      chk("bright5_active", act, 40);
      run_to(640);
      brightness = 4'd15;

      // Stage data, then reset while digit 4 is lit: staged data must vanish.
      run_to(670);
      do_load(24'h888888, 6'b000000, 6'b000000);
      run_to(705);
      chk("pre_rst_pos", position, 6'h3D);
      chk("pre_rst_segs", digit_segs, 8'hF8);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_pos", position, 6'h3F);
      chk("post_rst_segs", digit_segs, 8'hFF);
      chk("post_rst_fd", frame_done, 1'b0);
      rst = 1'b0;
      cyc = 0;

      act = 0; fd_first = -1;
      while (cyc < 69) begin
         step();
         if (position !== 6'h3F) act++;
         if (frame_done && fd_first < 0) fd_first = cyc;
      end
      chk("staged_dropped", act, 0);
      chk("rst_fd_first", fd_first, 60);
      run_to(70);
      do_load(24'h000009, 6'b000000, 6'b111110);
      run_to(120);
      chk("rst_fd_120", frame_done, 1'b1);
      run_to(125);
      chk("after_rst_pos", position, 6'h1F);
      chk("after_rst_segs", digit_segs, 8'h90);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
